// File: rtl/weight_sum_pkg.sv
// rtl/weight_sum_pkg.sv - shared state encoding, default widths and Q32.32 saturation limits
//
// Purpose:
//   Common definitions for the weight-sum accumulator slice. The top module
//   and the saturating adder import this package so that the sequencer
//   states and the default Q32.32 format are defined in exactly one place.
//
// Contents:
//   *_DEF            default parameter values for the accumulator
//   SAT_MAX/SAT_MIN  signed Q32.32 clamp values for 64-bit sums
//   ws_state_e       IDLE / ACCUM / DRAIN sequencer states

package weight_sum_pkg;

  // Default Q32.32 format: 32 integer bits, 32 fractional bits.
  localparam int INTEGER_WIDTH_DEF   = 32;
  localparam int DATA_WIDTH_FRAC_DEF = 32;
  localparam int DATA_WIDTH_DEF      = INTEGER_WIDTH_DEF + DATA_WIDTH_FRAC_DEF;

  // Sixteen neurons per accumulator by default.
  localparam int NEURON_ID_WIDTH_DEF = 4;

  // Largest and smallest representable signed Q32.32 values.
  localparam logic [63:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MIN = 64'h8000_0000_0000_0000;

  // Per-timestep sequencer.
  //   IDLE  : waiting for Start; sums from the previous step stay readable
  //   ACCUM : accepting one weighted event per cycle
  //   DRAIN : presenting one (excitatory, inhibitory) pair per neuron
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } ws_state_e;

endpackage

// File: rtl/sat_add_q.sv
// rtl/sat_add_q.sv - signed combinational saturating adder with overflow flag
//
// Purpose:
//   Adds two signed fixed-point values of equal width. When the true sum
//   falls outside the representable range the result is clamped to the
//   signed maximum or minimum and the overflow flag is raised. The binary
//   point position is irrelevant here, so the same block serves any Qm.n
//   format of width DATA_WIDTH.
//
// Ports:
//   a         in   DATA_WIDTH  signed addend (stored sum)
//   b         in   DATA_WIDTH  signed addend (incoming weight)
//   sum       out  DATA_WIDTH  saturated a + b
//   overflow  out  1           high when the result was clamped

module sat_add_q
  import weight_sum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  overflow
);

  localparam logic [DATA_WIDTH-1:0] POS_LIMIT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_LIMIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] raw_sum;
  logic                  a_neg;
  logic                  b_neg;
  logic                  raw_neg;

  assign raw_sum = a + b;
  assign a_neg   = a[DATA_WIDTH-1];
  assign b_neg   = b[DATA_WIDTH-1];
  assign raw_neg = raw_sum[DATA_WIDTH-1];

  // Two's-complement addition can only leave the range when both operands
  // share a sign and the wrapped result shows the opposite sign. The
  // direction of the clamp follows the operands' common sign.
  always_comb begin
    overflow = (a_neg == b_neg) && (raw_neg != a_neg);
    sum      = raw_sum;
    if (overflow) begin
      sum = a_neg ? NEG_LIMIT : POS_LIMIT;
    end
  end

endmodule

// File: rtl/weight_sum_accumulator.sv
// rtl/weight_sum_accumulator.sv - per-timestep excitatory/inhibitory synaptic weight integrator
//
// Purpose:
//   Integrates a stream of weighted spike events into per-neuron excitatory
//   and inhibitory Q32.32 sums during a timestep, then drains one pair per
//   neuron, in index order, to the neuron-update stage.
//
// Ports:
//   Clock            in   1                single clock, rising edge
//   Reset            in   1                asynchronous active-low reset
//   Start            in   1                open a new timestep (IDLE only)
//   EndOfStep        in   1                close the timestep (ACCUM only)
//   EventValid       in   1                event present
//   EventReady       out  1                event accepted this cycle when valid
//   EventNeuronID    in   NEURON_ID_WIDTH  target neuron
//   EventInhibitory  in   1                0 = excitatory sum, 1 = inhibitory sum
//   EventWeight      in   DATA_WIDTH       signed Q32.32 weight
//   OutValid         out  1                drained pair valid
//   OutReady         in   1                neuron stage accepts pair
//   OutNeuronID      out  NEURON_ID_WIDTH  index of drained pair
//   ExWeightSum      out  DATA_WIDTH       excitatory sum for OutNeuronID
//   InWeightSum      out  DATA_WIDTH       inhibitory sum for OutNeuronID
//   DrainDone        out  1                one-cycle pulse after last pair accepted
//   Overflow         out  1                sticky saturation flag for this timestep

module weight_sum_accumulator
  import weight_sum_pkg::*;
#(
  parameter int INTEGER_WIDTH   = INTEGER_WIDTH_DEF,
  parameter int DATA_WIDTH_FRAC = DATA_WIDTH_FRAC_DEF,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       EndOfStep,
  input  logic                       EventValid,
  output logic                       EventReady,
  input  logic [NEURON_ID_WIDTH-1:0] EventNeuronID,
  input  logic                       EventInhibitory,
  input  logic [DATA_WIDTH-1:0]      EventWeight,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [NEURON_ID_WIDTH-1:0] OutNeuronID,
  output logic [DATA_WIDTH-1:0]      ExWeightSum,
  output logic [DATA_WIDTH-1:0]      InWeightSum,
  output logic                       DrainDone,
  output logic                       Overflow
);

  localparam int NUM_NEURONS = 2 ** NEURON_ID_WIDTH;
  localparam logic [NEURON_ID_WIDTH-1:0] LAST_INDEX = NEURON_ID_WIDTH'(NUM_NEURONS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  ws_state_e                  state_q;
  ws_state_e                  state_d;
  logic [NEURON_ID_WIDTH-1:0] index_q;
  logic [NEURON_ID_WIDTH-1:0] index_d;
  logic                       overflow_q;
  logic                       drain_done_q;

  // Flip-flop register file: the whole array must clear in one edge on
  // Start and support a read-modify-write every cycle, which rules out RAM.
  logic [DATA_WIDTH-1:0] ex_sum_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] in_sum_q [NUM_NEURONS];

  // ---------------------------------------------------------------------
  // Sequencer control
  // ---------------------------------------------------------------------
  logic event_ready;
  logic out_valid;
  logic step_open;
  logic last_fire;
  logic event_accept;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    event_ready = 1'b0;
    out_valid   = 1'b0;
    step_open   = 1'b0;
    last_fire   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = ACCUM;
          step_open = 1'b1;
        end
      end

      ACCUM: begin
        event_ready = 1'b1;
        if (EndOfStep) begin
          state_d = DRAIN;
          index_d = '0;
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        if (OutReady) begin
          if (index_q == LAST_INDEX) begin
            state_d   = IDLE;
            index_d   = '0;
            last_fire = 1'b1;
          end else begin
            index_d = index_q + NEURON_ID_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // An event offered in the EndOfStep cycle is still accepted because
  // EventReady depends only on being in ACCUM.
  assign event_accept = event_ready && EventValid;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      drain_done_q <= last_fire;
    end
  end

  // ---------------------------------------------------------------------
  // Accumulate path: one saturating adder shared by both sum banks; the
  // bank select happens on the read mux and on the write-back.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rmw_old;
  logic [DATA_WIDTH-1:0] rmw_new;
  logic                  rmw_ovf;

  assign rmw_old = EventInhibitory ? in_sum_q[EventNeuronID] : ex_sum_q[EventNeuronID];

  sat_add_q #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat_add (
    .a        (rmw_old),
    .b        (EventWeight),
    .sum      (rmw_new),
    .overflow (rmw_ovf)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ex_sum_q[i] <= '0;
        in_sum_q[i] <= '0;
      end
    end else if (step_open) begin
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ex_sum_q[i] <= '0;
        in_sum_q[i] <= '0;
      end
    end else if (event_accept) begin
      if (EventInhibitory) begin
        in_sum_q[EventNeuronID] <= rmw_new;
      end else begin
        ex_sum_q[EventNeuronID] <= rmw_new;
      end
      if (rmw_ovf) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The sum outputs are a plain mux on the drain index, so they also show
  // neuron 0's retained sums while idle; consumers qualify with OutValid.
  assign EventReady  = event_ready;
  assign OutValid    = out_valid;
  assign OutNeuronID = index_q;
  assign ExWeightSum = ex_sum_q[index_q];
  assign InWeightSum = in_sum_q[index_q];
  assign DrainDone   = drain_done_q;
  assign Overflow    = overflow_q;

endmodule

// File: doc/weight_sum_accumulator.md
# weight_sum_accumulator

Per-timestep synaptic input integrator that sits directly upstream of the conductance LIF neuron unit. It accepts a stream of weighted spike events, each tagged with a target neuron and a synapse type, and sums them per neuron into separate excitatory and inhibitory Q32.32 weight sums. At end of timestep it drains one (ExWeightSum, InWeightSum) pair per neuron, in neuron order, to the neuron-update stage through a valid/ready handshake.

## Interface
- INTEGER_WIDTH, 32, integer bits of weight sums
- DATA_WIDTH_FRAC, 32, fractional bits of weight sums
- DATA_WIDTH, 64, INTEGER_WIDTH + DATA_WIDTH_FRAC; signed Q32.32 weight and sum width
- NEURON_ID_WIDTH, 4, neuron index width; NUM_NEURONS = 2**NEURON_ID_WIDTH

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  pulse: open a new timestep (honoured only in IDLE)
- EndOfStep  in  1  pulse: no more events this timestep (honoured only in ACCUM)
- EventValid  in  1  event present
- EventReady  out  1  accumulator accepts event
- EventNeuronID  in  NEURON_ID_WIDTH  target neuron
- EventInhibitory  in  1  0 = excitatory sum, 1 = inhibitory sum
- EventWeight  in  DATA_WIDTH  signed Q32.32 weight
- OutValid  out  1  drained pair valid
- OutReady  in  1  neuron stage accepts pair
- OutNeuronID  out  NEURON_ID_WIDTH  index of drained pair
- ExWeightSum  out  DATA_WIDTH  excitatory sum for OutNeuronID
- InWeightSum  out  DATA_WIDTH  inhibitory sum for OutNeuronID
- DrainDone  out  1  one-cycle pulse after final pair accepted
- Overflow  out  1  sticky: some addition saturated this timestep

## Operation
- States: IDLE, ACCUM, DRAIN. Reset -> IDLE.
- IDLE: EventReady=0, OutValid=0. Start -> clear all 2*NUM_NEURONS sums and Overflow in the same edge; next state ACCUM.
- ACCUM: EventReady=1. On EventValid&&EventReady, sum[EventInhibitory][EventNeuronID] += EventWeight. Addition saturates at signed DATA_WIDTH max/min; any saturation sets Overflow.
- EndOfStep in ACCUM -> DRAIN, index=0. An event accepted in the same cycle as EndOfStep is included in the sums.
- DRAIN: EventReady=0, OutValid=1, OutNeuronID=index, ExWeightSum/InWeightSum = stored sums at index (combinational mux from register file). On OutValid&&OutReady: if index==NUM_NEURONS-1 -> IDLE and pulse DrainDone next cycle; else index+1. OutReady low holds outputs stable.
- Start outside IDLE, EndOfStep outside ACCUM: ignored. Events offered outside ACCUM are not accepted, because EventReady=0.
- Sums keep their values after drain until the next Start.

## Timing
- Reset values: state IDLE, all sums 0, index 0, EventReady 0, OutValid 0, OutNeuronID 0, ExWeightSum/InWeightSum 0, DrainDone 0, Overflow 0.
- Reset asserted mid-ACCUM or mid-DRAIN: immediate return to reset values; a partially drained step is discarded.
- Throughput: one event per cycle in ACCUM, including repeated hits on the same neuron. The read-modify-write completes in one cycle, so there is no hazard.
- An event accepted at edge k is visible in the sum register after edge k.
- Start at edge k -> EventReady=1 from cycle k+1.
- EndOfStep at edge k -> OutValid=1 for neuron 0 from cycle k+1.
- Minimum drain length is NUM_NEURONS cycles with OutReady held high. DrainDone is high in the cycle after the last handshake, coincident with the return to IDLE.

## Structure
- Shared package weight_sum_pkg: state enum (IDLE, ACCUM, DRAIN), default width constants, and Q32.32 SAT_MAX/SAT_MIN constants.
- One sub-module, sat_add_q: signed DATA_WIDTH combinational saturating adder with an overflow flag. It is instantiated once in the accumulate path. The excitatory/inhibitory select is done on the write-back.
- Sums are held in a flip-flop register file (NUM_NEURONS x 2 x DATA_WIDTH), not RAM, because of the single-cycle clear and the RMW requirement.

## Test plan
- Basic accumulation: Start; events (n3, ex, +1.5), (n3, ex, +2.0), (n3, in, +0.25), (n0, ex, -1.0); EndOfStep; OutReady=1 -> 16 pairs in order; n3 = (3.5, 0.25), n0 = (-1.0, 0), all others 0; DrainDone 16 cycles after entering DRAIN.
- Saturation: two events (n5, ex, 0x7FFFFFFF_00000000) -> n5 Ex = 0x7FFFFFFF_FFFFFFFF and Overflow=1. Repeat with negative weights -> 0x80000000_00000000. Overflow clears on the next Start.
- Backpressure and boundary: OutReady toggling 1,0,0,1 -> OutNeuronID and sums held while OutReady=0; no index skips; index 15 handshake -> IDLE.
- Simultaneous and ignored controls: event (n2, ex, +1.0) in the same cycle as EndOfStep -> included. Start during DRAIN and EndOfStep in IDLE -> no state change. EventValid in IDLE -> EventReady=0, sums unchanged.
- Reset mid-drain: assert Reset at index 7 -> OutValid=0 immediately, all outputs at reset values. The next Start/EndOfStep with no events -> all pairs 0.
- Back-to-back steps: the second Start clears the first step's sums; 16 consecutive one-per-cycle events to one neuron -> exact sum, no dropped events.
